pool_result_writer: RTL and testbench

Output-side stage directly downstream of the max-pooling top level. Accepts the packed 64-bit pooled words (four signed 16-bit lanes) with their target address and the per-channel done pulse. Optionally applies per-lane ReLU, buffers results in a small FIFO, and writes them to the output BRAM port whenever the shared port is granted. Tracks completed channels and flags end-of-layer.

---
 rtl/pool_result_writer_if.sv | 35 +++
 rtl/pool_result_writer.sv | 114 +++++++++++
 tb/tb_pool_result_writer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pool_result_writer_if.sv
`default_nettype none
// ============================================================================
// pool_result_writer_if : pooled-word input, BRAM write port and status bus
// Revision: 1.0
// ============================================================================
interface pool_result_writer_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [63:0]   in_data;
    logic          in_valid;
    logic [15:0]   in_address;
    logic          in_done;
    logic          relu_en;
    logic          wr_gnt;
    logic          wr_en;
    logic [15:0]   wr_addr;
    logic [63:0]   wr_data;
    logic [9:0]    ch_cnt;
    logic          all_done;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    modport master (
        output in_data, in_valid, in_address, in_done, relu_en, wr_gnt,
        input  wr_en, wr_addr, wr_data, ch_cnt, all_done, overflow, fifo_level
    );

    modport slave (
        input  in_data, in_valid, in_address, in_done, relu_en, wr_gnt,
        output wr_en, wr_addr, wr_data, ch_cnt, all_done, overflow, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/pool_result_writer.sv
`default_nettype none
// ============================================================================
// pool_result_writer : ReLU, small FIFO and granted BRAM writes of pooled words
// Revision: 1.0
// ============================================================================
module pool_result_writer #(
    parameter int DEPTH  = 4,
    parameter int NUM_CH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    pool_result_writer_if.slave  bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL   = (AW + 1)'(DEPTH);
    localparam logic [9:0]  C_NUM_CH = 10'(NUM_CH);

    logic [63:0]    mem_data_q [DEPTH];
    logic [15:0]    mem_addr_q [DEPTH];
    logic [DEPTH-1:0] mem_tag_q;
    logic [DEPTH-1:0] mem_has_data_q;

    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;
    logic           wr_en_q;
    logic [15:0]    wr_addr_q;
    logic [63:0]    wr_data_q;
    logic [9:0]     ch_cnt_q;
    logic           all_done_q;
    logic           overflow_q;

    logic [63:0]    relu_data;
    logic           push_req, push_ok, pop, empty, full;
    logic           head_tag, head_has_data;

    always_comb begin
        relu_data = bus.in_data;
        for (int k = 0; k < 4; k++) begin
            if (bus.relu_en && bus.in_data[16*k+15]) begin
                relu_data[16*k +: 16] = 16'h0000;
            end
        end
    end

    assign empty         = (count_q == '0);
    assign full          = (count_q == C_FULL);
    assign head_tag      = mem_tag_q[rd_ptr_q];
    assign head_has_data = mem_has_data_q[rd_ptr_q];
    assign push_req      = bus.in_valid | bus.in_done;
    // Tag-only markers never need the port, so they retire without a grant.
    assign pop           = !empty && (bus.wr_gnt || !head_has_data);
    assign push_ok       = push_req && (!full || pop);

    // Storage is unreset; validity is carried entirely by the pointers/count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data_q[wr_ptr_q]     <= bus.in_valid ? relu_data : 64'h0;
            mem_addr_q[wr_ptr_q]     <= bus.in_valid ? bus.in_address : 16'h0;
            mem_tag_q[wr_ptr_q]      <= bus.in_done;
            mem_has_data_q[wr_ptr_q] <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 16'h0;
            wr_data_q  <= 64'h0;
            ch_cnt_q   <= 10'd0;
            all_done_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            wr_en_q <= pop && head_has_data;
            if (pop && head_has_data) begin
                wr_addr_q <= mem_addr_q[rd_ptr_q];
                wr_data_q <= mem_data_q[rd_ptr_q];
            end

            if (pop && head_tag && (ch_cnt_q != 10'h3FF)) begin
                ch_cnt_q <= ch_cnt_q + 1'b1;
            end
            if (ch_cnt_q >= C_NUM_CH) begin
                all_done_q <= 1'b1;
            end
            if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.ch_cnt     = ch_cnt_q;
    assign bus.all_done   = all_done_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_level = count_q;
endmodule
`default_nettype wire

// File: tb/tb_pool_result_writer.sv
`default_nettype none
// ============================================================================
// tb_pool_result_writer : cycle table plus hand sequences for pool_result_writer
// Revision: 1.0
// ============================================================================
module tb_pool_result_writer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pool_result_writer_if #(.DEPTH(4)) bus ();

    pool_result_writer #(.DEPTH(4), .NUM_CH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst, vld, done, relu, gnt;
        logic [15:0] addr;
        logic [63:0] data;
        logic        e_we;
        logic [15:0] e_addr;
        logic [63:0] e_data;
        logic [9:0]  e_ch;
        logic [2:0]  e_lvl;
        logic        e_ovf, e_all;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [63:0] D  = 64'h0004_0003_0002_0001;
    localparam logic [63:0] R  = 64'h8000_7FFF_FFFF_0001;
    localparam logic [63:0] RR = 64'h0000_7FFF_0000_0001;
    localparam logic [63:0] O  = 64'h1111_0000_0000_0000;
    localparam logic [63:0] X  = 64'hFFFF_8000_1234_0042;

    task automatic add(input logic r, v, d, rl, g, input logic [15:0] a, input logic [63:0] dt,
                       input logic we, input logic [15:0] ea, input logic [63:0] ed,
                       input logic [9:0] ch, input logic [2:0] lv, input logic ov, input logic al);
        vec_t t;
        t.rst = r; t.vld = v; t.done = d; t.relu = rl; t.gnt = g; t.addr = a; t.data = dt;
        t.e_we = we; t.e_addr = ea; t.e_data = ed; t.e_ch = ch; t.e_lvl = lv;
        t.e_ovf = ov; t.e_all = al;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, v, d, rl, g, input logic [15:0] a, input logic [63:0] dt);
        rst = r; bus.in_valid = v; bus.in_done = d; bus.relu_en = rl; bus.wr_gnt = g;
        bus.in_address = a; bus.in_data = dt;
    endtask

    task automatic check(input string name, input logic ok, input string got, input string want);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %s, expected %s", name, got, want);
        end
    endtask

    initial begin
        int n;
        int wr_seen;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0);

        // reset
        add(1,0,0,0,0, 16'h0,  64'h0,  0,16'h0,64'h0, 0,0,0,0);
        // four pushes, grant held
        for (int k = 0; k < 4; k++)
            add(0,1,0,0,1, 16'(k), D, (k > 0), 16'(k > 0 ? k-1 : 0), (k > 0) ? D : 64'h0, 0,1,0,0);
        add(0,0,0,0,1, 16'h0, 64'h0, 1,16'h3,D, 0,0,0,0);
        add(0,0,0,0,1, 16'h0, 64'h0, 0,16'h3,D, 0,0,0,0);
        // relu on, then off
        add(0,1,0,1,1, 16'h10, R, 0,16'h3,D, 0,1,0,0);
        add(0,1,0,0,1, 16'h11, R, 1,16'h10,RR, 0,1,0,0);
        add(0,0,0,0,1, 16'h0, 64'h0, 1,16'h11,R, 0,0,0,0);
        add(0,0,0,0,1, 16'h0, 64'h0, 0,16'h11,R, 0,0,0,0);
        // five pushes without grant into a 4-deep FIFO
        for (int k = 0; k < 5; k++)
            add(0,1,0,0,0, 16'(32+k), O + 64'(k), 0,16'h11,R, 0, 3'(k < 4 ? k+1 : 4), (k == 4), 0);
        // grant while full plus a push: accepted
        add(0,1,0,0,1, 16'h25, O + 64'd5, 1,16'h20,O, 0,4,1,0);
        add(0,0,0,0,1, 16'h0, 64'h0, 1,16'h21,O+64'd1, 0,3,1,0);
        add(0,0,0,0,1, 16'h0, 64'h0, 1,16'h22,O+64'd2, 0,2,1,0);
        add(0,0,0,0,1, 16'h0, 64'h0, 1,16'h23,O+64'd3, 0,1,1,0);
        add(0,0,0,0,1, 16'h0, 64'h0, 1,16'h25,O+64'd5, 0,0,1,0);
        add(0,0,0,0,1, 16'h0, 64'h0, 0,16'h25,O+64'd5, 0,0,1,0);
        // done markers: tag-only, then with data
        add(0,0,1,0,1, 16'h0, 64'h0, 0,16'h25,O+64'd5, 0,1,1,0);
        add(0,1,1,0,1, 16'h64, X, 0,16'h25,O+64'd5, 1,1,1,0);
        add(0,0,0,0,1, 16'h0, 64'h0, 1,16'h64,X, 2,0,1,0);
        add(0,0,0,0,1, 16'h0, 64'h0, 0,16'h64,X, 2,0,1,1);
        // tag-only marker retires without grant
        add(0,0,1,0,0, 16'h0, 64'h0, 0,16'h64,X, 2,1,1,1);
        add(0,0,0,0,0, 16'h0, 64'h0, 0,16'h64,X, 3,0,1,1);
        // buffer three entries, then reset mid-stream
        for (int k = 0; k < 3; k++)
            add(0,1,0,0,0, 16'(112+k), 64'(k+1), 0,16'h64,X, 3,3'(k+1),1,1);
        add(1,1,0,0,1, 16'h99, 64'h99, 0,16'h0,64'h0, 0,0,0,0);
        add(0,0,0,0,1, 16'h0, 64'h0, 0,16'h0,64'h0, 0,0,0,0);
        add(0,0,0,0,1, 16'h0, 64'h0, 0,16'h0,64'h0, 0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].done, vecs[i].relu, vecs[i].gnt,
                  vecs[i].addr, vecs[i].data);
            @(posedge clk);
            #1;
            check($sformatf("row%0d", i),
                  bus.wr_en == vecs[i].e_we && bus.wr_addr == vecs[i].e_addr &&
                  bus.wr_data == vecs[i].e_data && bus.ch_cnt == vecs[i].e_ch &&
                  bus.fifo_level == vecs[i].e_lvl && bus.overflow == vecs[i].e_ovf &&
                  bus.all_done == vecs[i].e_all,
                  $sformatf("we=%b a=%h d=%h ch=%0d lvl=%0d ovf=%b all=%b", bus.wr_en, bus.wr_addr,
                            bus.wr_data, bus.ch_cnt, bus.fifo_level, bus.overflow, bus.all_done),
                  $sformatf("we=%b a=%h d=%h ch=%0d lvl=%0d ovf=%b all=%b", vecs[i].e_we,
                            vecs[i].e_addr, vecs[i].e_data, vecs[i].e_ch, vecs[i].e_lvl,
                            vecs[i].e_ovf, vecs[i].e_all));
        end

        // first-write latency from an empty FIFO, bounded wait
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h55, 64'hABCD);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 64'h0);
        n = 0;
        while (n < 6 && !bus.wr_en) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_edges", n == 1, $sformatf("%0d", n + 1), "2");
        check("latency_word", bus.wr_addr == 16'h55 && bus.wr_data == 64'hABCD,
              $sformatf("%h/%h", bus.wr_addr, bus.wr_data), "0055/000000000000abcd");

        // ch_cnt saturation with a stream of tag-only markers, no grant
        wr_seen = 0;
        for (int k = 0; k < 1030; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 64'h0);
            @(posedge clk);
            #1;
            if (bus.wr_en) wr_seen++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        check("marker_no_write", wr_seen == 0, $sformatf("%0d", wr_seen), "0");
        check("ch_cnt_sat", bus.ch_cnt == 10'd1023, $sformatf("%0d", bus.ch_cnt), "1023");
        check("sat_status", bus.all_done && !bus.overflow && bus.fifo_level == 3'd0,
              $sformatf("all=%b ovf=%b lvl=%0d", bus.all_done, bus.overflow, bus.fifo_level),
              "all=1 ovf=0 lvl=0");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
